ddr2_ctrl_cmd_stage: RTL and testbench
======================================

DDR2_CTRL_CMD_STAGE -- requirements
Module: ddr2_ctrl_cmd_stage

Interface
REQ-001 Parameter ROW_ADDRESS, default 14: width of the address bus.
REQ-002 Parameter BANK_ADDRESS, default 3: width of the bank-address bus.
REQ-003 Parameter CS_WIDTH, default 1: number of chip selects (ranks).
REQ-004 Parameter CKE_WIDTH, default 1: number of clock-enable bits.
REQ-005 Parameter ODT_WIDTH, default 1: number of ODT bits.
REQ-006 Parameter OUT_STAGES, default 1, legal 1..3: number of output register stages.
REQ-007 The block SHALL have one clock, clk0, and a synchronous, active-high reset, rst0.
REQ-008 Port list, in order (name, direction, width, meaning):
- clk0, in, 1: clock.
- rst0, in, 1: synchronous active-high reset.
- ctrl_cmd_valid, in, 1: a command is present on the ctrl_ddr2_* command fields.
- ctrl_cmd_ready, out, 1: the stage accepts a command this cycle.
- ctrl_ddr2_address, in, ROW_ADDRESS: command address.
- ctrl_ddr2_ba, in, BANK_ADDRESS: command bank address.
- ctrl_ddr2_ras_l, ctrl_ddr2_cas_l, ctrl_ddr2_we_l, in, 1 each: active-low command bits.
- ctrl_ddr2_cs_l, in, CS_WIDTH: active-low rank select.
- ctrl_ddr2_cke, in, CKE_WIDTH: level control, not handshaked.
- ctrl_ddr2_odt, in, ODT_WIDTH: level control, not handshaked.
- ddr_address, ddr_ba, ddr_ras_l, ddr_cas_l, ddr_we_l, ddr_cs_l, ddr_cke, ddr_odt, out, matching widths: registered pad-side outputs.

Function
REQ-009 Accept: a command SHALL be accepted on a rising clk0 edge when ctrl_cmd_valid and ctrl_cmd_ready are both 1.
REQ-010 Idle cycles: when no command is accepted and no 2T second phase is pending, stage 0 SHALL load a NOP.
- ras_l, cas_l, we_l and cs_l SHALL all be 1.
- address and ba SHALL hold their previous values, to minimise toggling.
REQ-011 1T mode: ctrl_cmd_ready SHALL be 1 whenever rst0 is 0. An accepted command SHALL load into stage 0 unchanged.
REQ-012 Output latency: stage 0 SHALL feed a shift chain of OUT_STAGES registers in total. A command accepted at edge N SHALL appear on the ddr_* outputs after edge N+OUT_STAGES-1.
REQ-013 CKE/ODT: ctrl_ddr2_cke and ctrl_ddr2_odt SHALL be sampled every cycle regardless of the handshake. They SHALL pass through the same OUT_STAGES so they stay aligned with the command fields.
REQ-014 Registers only: the outputs SHALL be driven directly from the final register stage, with no combinational path from any input to any output.

Reset
REQ-015 While rst0 is 1 at an edge, every stage SHALL load the reset values:
- ras_l, cas_l, we_l: 1.
- cs_l: all 1.
- cke: all 0.
- odt: all 0.
- address: 0.
- ba: 0.
REQ-016 While rst0 is 1, ctrl_cmd_ready SHALL be 0. Any pending 2T phase SHALL be discarded, and the discarded command SHALL never reach the outputs.
REQ-017 The first accept after reset SHALL be possible at the first edge at which rst0 is 0.

Configuration
REQ-018 Macro DDR2_2T_TIMING_EN SHALL select the 2T mode below when defined.
- 2T mode: every command occupies two clk0 cycles.
- Phase A (accept edge): stage 0 SHALL load address, ba, ras_l, cas_l and we_l, with cs_l forced to all 1.
- Phase B (next edge): stage 0 SHALL reload the same captured fields with the captured cs_l.
- ctrl_cmd_ready SHALL be 0 during the cycle after an accept, so the accept rate is at most one command per 2 cycles.
- An input change during phase B SHALL NOT affect the captured command.
REQ-019 When DDR2_2T_TIMING_EN is undefined, the block SHALL implement 1T mode (REQ-011) only, and the phase state SHALL NOT exist.

Structure
REQ-020 The reset-value constants (NOP encoding {ras,cas,we}=3'b111, CS idle all-ones, CKE/ODT idle 0) SHALL reside in the shared DDR2 parameters include, alongside the width macros.
REQ-021 A single sub-module, ddr2_ctrl_pipe_reg, SHALL implement one parametrised-width stage with a synchronous reset-value input. It SHALL be instantiated OUT_STAGES times via generate.
REQ-022 The 2T phase logic SHALL be a two-state FSM (IDLE, PHASE_B) in the top level.

Verification
REQ-023 Reset release, OUT_STAGES=2: hold rst0=1 for 3 cycles with random inputs. Required: outputs ras/cas/we/cs=1, cke=odt=0, address=0, ba=0, and ready=0 throughout.
REQ-024 1T back-to-back, OUT_STAGES=1: ACT (ras_l=0, address=0x1A5, ba=2), then READ (cas_l=0, address=0x010), then valid=0. Required: ACT on the outputs after edge N, READ after edge N+1, NOP with address=0x010 held after that.
REQ-025 2T, OUT_STAGES=1: hold valid=1 with WRITE (cas_l=0, we_l=0, cs_l=0, address=0x3F0). Required:
- Cycle 1: address=0x3F0 with cs_l=1.
- Cycle 2: same fields with cs_l=0.
- ready pattern: 1,0,1,0.
- A second command changed during phase B is not sampled.
REQ-026 2T reset mid-command: assert rst0 in phase B. Required: cs_l is never 0 for that command, and the outputs return to the REQ-015 values.
REQ-027 CKE/ODT, OUT_STAGES=3: toggle cke 0→1 at edge M with valid=0. Required: ddr_cke=1 after edge M+2, aligned with a command issued at the same edge.

Source files
------------

// File: rtl/ddr2_ctrl_cmd_stage_pkg.sv
// Shared DDR2 command-stage constants: idle/reset encodings of the pad-side
// command fields and the 2T phase state type.
package ddr2_ctrl_cmd_stage_pkg;

  // {ras_l, cas_l, we_l} for a NOP / deselect.
  localparam logic [2:0] DDR2_NOP_CMD = 3'b111;
  // Per-bit idle levels for rank select, clock enable and on-die termination.
  localparam logic DDR2_CS_IDLE  = 1'b1;
  localparam logic DDR2_CKE_IDLE = 1'b0;
  localparam logic DDR2_ODT_IDLE = 1'b0;

  // Output register depth limits.
  localparam int DDR2_MIN_STAGES = 1;
  localparam int DDR2_MAX_STAGES = 3;

  // Phase of a 2T command: IDLE accepts, PHASE_B re-drives with cs_l asserted.
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PHASE_B = 1'b1
  } ddr2_phase_e;

  // Clamp a requested stage count into the supported range.
  function automatic int ddr2_clamp_stages(input int req);
    if (req < DDR2_MIN_STAGES) return DDR2_MIN_STAGES;
    if (req > DDR2_MAX_STAGES) return DDR2_MAX_STAGES;
    return req;
  endfunction

endpackage

// File: rtl/ddr2_ctrl_pipe_reg.sv
// One output register stage of the DDR2 command path, with a synchronous
// load of a caller-supplied reset value.
module ddr2_ctrl_pipe_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rst_val,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] data_q;

  // Next value is simply the upstream stage.
  always_comb begin
    data_d = d;
  end

  // Stage register; reset forces the idle encoding.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= rst_val;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/ddr2_ctrl_cmd_stage.sv
// DDR2 controller command output stage. Accepts one command per handshake,
// drives NOPs on idle cycles while holding address/bank to limit toggling, and
// pushes the command plus the unhandshaked CKE/ODT levels through OUT_STAGES
// registers so the pads are driven straight from flops.
// Optional feature: define DDR2_2T_TIMING_EN for 2T command timing, where each
// command is held two cycles with chip select asserted only in the second.
module ddr2_ctrl_cmd_stage
  import ddr2_ctrl_cmd_stage_pkg::*;
#(
  parameter int ROW_ADDRESS  = 14,
  parameter int BANK_ADDRESS = 3,
  parameter int CS_WIDTH     = 1,
  parameter int CKE_WIDTH    = 1,
  parameter int ODT_WIDTH    = 1,
  parameter int OUT_STAGES   = 1
) (
  input  logic                    clk0,
  input  logic                    rst0,
  input  logic                    ctrl_cmd_valid,
  output logic                    ctrl_cmd_ready,
  input  logic [ROW_ADDRESS-1:0]  ctrl_ddr2_address,
  input  logic [BANK_ADDRESS-1:0] ctrl_ddr2_ba,
  input  logic                    ctrl_ddr2_ras_l,
  input  logic                    ctrl_ddr2_cas_l,
  input  logic                    ctrl_ddr2_we_l,
  input  logic [CS_WIDTH-1:0]     ctrl_ddr2_cs_l,
  input  logic [CKE_WIDTH-1:0]    ctrl_ddr2_cke,
  input  logic [ODT_WIDTH-1:0]    ctrl_ddr2_odt,
  output logic [ROW_ADDRESS-1:0]  ddr_address,
  output logic [BANK_ADDRESS-1:0] ddr_ba,
  output logic                    ddr_ras_l,
  output logic                    ddr_cas_l,
  output logic                    ddr_we_l,
  output logic [CS_WIDTH-1:0]     ddr_cs_l,
  output logic [CKE_WIDTH-1:0]    ddr_cke,
  output logic [ODT_WIDTH-1:0]    ddr_odt
);

  localparam int NSTG  = ddr2_clamp_stages(OUT_STAGES);
  // Stage bus layout, MSB first: address, ba, ras_l, cas_l, we_l, cs_l, cke, odt.
  localparam int BUS_W = ROW_ADDRESS + BANK_ADDRESS + 3 + CS_WIDTH + CKE_WIDTH + ODT_WIDTH;

  logic [BUS_W-1:0] rst_val;
  logic [BUS_W-1:0] s0_d;
  logic [BUS_W-1:0] stg_q [NSTG];

  // Stage-0 fields as computed for the next edge.
  logic [ROW_ADDRESS-1:0]  s0_addr_d;
  logic [BANK_ADDRESS-1:0] s0_ba_d;
  logic [2:0]              s0_cmd_d;
  logic [CS_WIDTH-1:0]     s0_cs_d;

  // Stage-0 address/bank currently held, used to repeat them on NOP cycles.
  logic [ROW_ADDRESS-1:0]  s0_addr_q;
  logic [BANK_ADDRESS-1:0] s0_ba_q;

  logic accept;

  assign rst_val = {{ROW_ADDRESS{1'b0}}, {BANK_ADDRESS{1'b0}}, DDR2_NOP_CMD,
                    {CS_WIDTH{DDR2_CS_IDLE}}, {CKE_WIDTH{DDR2_CKE_IDLE}},
                    {ODT_WIDTH{DDR2_ODT_IDLE}}};

  assign s0_addr_q = stg_q[0][BUS_W-1 -: ROW_ADDRESS];
  assign s0_ba_q   = stg_q[0][BUS_W-ROW_ADDRESS-1 -: BANK_ADDRESS];

  assign accept = ctrl_cmd_valid & ctrl_cmd_ready;

`ifdef DDR2_2T_TIMING_EN

  ddr2_phase_e             state_d, state_q;
  logic [ROW_ADDRESS-1:0]  cap_addr_d, cap_addr_q;
  logic [BANK_ADDRESS-1:0] cap_ba_d, cap_ba_q;
  logic [2:0]              cap_cmd_d, cap_cmd_q;
  logic [CS_WIDTH-1:0]     cap_cs_d, cap_cs_q;

  // Phase state register; reset drops any half-issued command.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture register holds the command for its second cycle; it is only read
  // in PHASE_B, which reset leaves, so it needs no reset of its own.
  always_ff @(posedge clk0) begin
    cap_addr_q <= cap_addr_d;
    cap_ba_q   <= cap_ba_d;
    cap_cmd_q  <= cap_cmd_d;
    cap_cs_q   <= cap_cs_d;
  end

  // Next-state: every accept is followed by exactly one PHASE_B cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = ST_PHASE_B;
      ST_PHASE_B: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs: ready only in IDLE, capture on accept, stage-0 field selection.
  always_comb begin
    ctrl_cmd_ready = ~rst0 & (state_q == ST_IDLE);
    cap_addr_d = cap_addr_q;
    cap_ba_d   = cap_ba_q;
    cap_cmd_d  = cap_cmd_q;
    cap_cs_d   = cap_cs_q;
    s0_addr_d  = s0_addr_q;
    s0_ba_d    = s0_ba_q;
    s0_cmd_d   = DDR2_NOP_CMD;
    s0_cs_d    = {CS_WIDTH{DDR2_CS_IDLE}};
    if (accept) begin
      cap_addr_d = ctrl_ddr2_address;
      cap_ba_d   = ctrl_ddr2_ba;
      cap_cmd_d  = {ctrl_ddr2_ras_l, ctrl_ddr2_cas_l, ctrl_ddr2_we_l};
      cap_cs_d   = ctrl_ddr2_cs_l;
      // First cycle: fields settle on the bus with the rank deselected.
      s0_addr_d  = ctrl_ddr2_address;
      s0_ba_d    = ctrl_ddr2_ba;
      s0_cmd_d   = {ctrl_ddr2_ras_l, ctrl_ddr2_cas_l, ctrl_ddr2_we_l};
    end else if (state_q == ST_PHASE_B) begin
      s0_addr_d  = cap_addr_q;
      s0_ba_d    = cap_ba_q;
      s0_cmd_d   = cap_cmd_q;
      s0_cs_d    = cap_cs_q;
    end
  end

`else

  // 1T: always ready out of reset; accepted commands pass unchanged.
  always_comb begin
    ctrl_cmd_ready = ~rst0;
    s0_addr_d      = s0_addr_q;
    s0_ba_d        = s0_ba_q;
    s0_cmd_d       = DDR2_NOP_CMD;
    s0_cs_d        = {CS_WIDTH{DDR2_CS_IDLE}};
    if (accept) begin
      s0_addr_d = ctrl_ddr2_address;
      s0_ba_d   = ctrl_ddr2_ba;
      s0_cmd_d  = {ctrl_ddr2_ras_l, ctrl_ddr2_cas_l, ctrl_ddr2_we_l};
      s0_cs_d   = ctrl_ddr2_cs_l;
    end
  end

`endif

  // CKE/ODT are sampled every cycle and ride alongside the command fields.
  always_comb begin
    s0_d = {s0_addr_d, s0_ba_d, s0_cmd_d, s0_cs_d, ctrl_ddr2_cke, ctrl_ddr2_odt};
  end

  for (genvar i = 0; i < NSTG; i++) begin : g_stage
    logic [BUS_W-1:0] stg_d;
    if (i == 0) begin : g_first
      assign stg_d = s0_d;
    end else begin : g_next
      assign stg_d = stg_q[i-1];
    end
    ddr2_ctrl_pipe_reg #(
      .DATA_W (BUS_W)
    ) u_reg (
      .clk     (clk0),
      .rst     (rst0),
      .rst_val (rst_val),
      .d       (stg_d),
      .q       (stg_q[i])
    );
  end

  assign {ddr_address, ddr_ba, ddr_ras_l, ddr_cas_l, ddr_we_l,
          ddr_cs_l, ddr_cke, ddr_odt} = stg_q[NSTG-1];

endmodule

// File: tb/tb_ddr2_ctrl_cmd_stage.sv
// Directed bench for ddr2_ctrl_cmd_stage: three instances (OUT_STAGES 1, 2, 3)
// share one stimulus stream. Build with DDR2_2T_TIMING_EN to cover 2T mode.
module tb_ddr2_ctrl_cmd_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [13:0] addr;
  logic [2:0]  ba;
  logic        ras, cas, we;
  logic [0:0]  cs, cke, odt;

  logic        rdy1, rdy2, rdy3;
  logic [13:0] a1, a2, a3;
  logic [2:0]  b1, b2, b3;
  logic        r1, r2, r3, c1, c2, c3, w1, w2, w3;
  logic [0:0]  s1, s2, s3, k1, k2, k3, o1, o2, o3;

  logic [22:0] bus1, bus2, bus3;
  assign bus1 = {a1, b1, r1, c1, w1, s1, k1, o1};
  assign bus2 = {a2, b2, r2, c2, w2, s2, k2, o2};
  assign bus3 = {a3, b3, r3, c3, w3, s3, k3, o3};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ddr2_ctrl_cmd_stage #(.OUT_STAGES(1)) u_dut1 (
    .clk0(clk), .rst0(rst), .ctrl_cmd_valid(valid), .ctrl_cmd_ready(rdy1),
    .ctrl_ddr2_address(addr), .ctrl_ddr2_ba(ba), .ctrl_ddr2_ras_l(ras),
    .ctrl_ddr2_cas_l(cas), .ctrl_ddr2_we_l(we), .ctrl_ddr2_cs_l(cs),
    .ctrl_ddr2_cke(cke), .ctrl_ddr2_odt(odt),
    .ddr_address(a1), .ddr_ba(b1), .ddr_ras_l(r1), .ddr_cas_l(c1),
    .ddr_we_l(w1), .ddr_cs_l(s1), .ddr_cke(k1), .ddr_odt(o1));

  ddr2_ctrl_cmd_stage #(.OUT_STAGES(2)) u_dut2 (
    .clk0(clk), .rst0(rst), .ctrl_cmd_valid(valid), .ctrl_cmd_ready(rdy2),
    .ctrl_ddr2_address(addr), .ctrl_ddr2_ba(ba), .ctrl_ddr2_ras_l(ras),
    .ctrl_ddr2_cas_l(cas), .ctrl_ddr2_we_l(we), .ctrl_ddr2_cs_l(cs),
    .ctrl_ddr2_cke(cke), .ctrl_ddr2_odt(odt),
    .ddr_address(a2), .ddr_ba(b2), .ddr_ras_l(r2), .ddr_cas_l(c2),
    .ddr_we_l(w2), .ddr_cs_l(s2), .ddr_cke(k2), .ddr_odt(o2));

  ddr2_ctrl_cmd_stage #(.OUT_STAGES(3)) u_dut3 (
    .clk0(clk), .rst0(rst), .ctrl_cmd_valid(valid), .ctrl_cmd_ready(rdy3),
    .ctrl_ddr2_address(addr), .ctrl_ddr2_ba(ba), .ctrl_ddr2_ras_l(ras),
    .ctrl_ddr2_cas_l(cas), .ctrl_ddr2_we_l(we), .ctrl_ddr2_cs_l(cs),
    .ctrl_ddr2_cke(cke), .ctrl_ddr2_odt(odt),
    .ddr_address(a3), .ddr_ba(b3), .ddr_ras_l(r3), .ddr_cas_l(c3),
    .ddr_we_l(w3), .ddr_cs_l(s3), .ddr_cke(k3), .ddr_odt(o3));

  // Pack an expected pad bundle in the same order as busN.
  function automatic logic [22:0] pk(input logic [13:0] ea, input logic [2:0] eb,
                                     input logic er, input logic ec, input logic ew,
                                     input logic es, input logic ek, input logic eo);
    return {ea, eb, er, ec, ew, es, ek, eo};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic v, input logic [13:0] ia, input logic [2:0] ib,
                     input logic ir, input logic ic, input logic iw, input logic is);
    valid = v; addr = ia; ba = ib; ras = ir; cas = ic; we = iw; cs = is;
  endtask

  logic [22:0] rst_bus;
  logic        cs_exp;

  initial begin
    rst_bus = pk(14'h0, 3'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    cke = 1'b0;
    odt = 1'b0;

    // Reset with random inputs for three cycles.
    for (int i = 0; i < 3; i++) begin
      cmd(1'($urandom), 14'($urandom), 3'($urandom), 1'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom));
      cke = 1'($urandom);
      odt = 1'($urandom);
      #1;
      chk("rst_rdy_in", {29'd0, rdy1, rdy2, rdy3}, 32'd0);
      step();
      chk("rst_bus2", 32'(bus2), 32'(rst_bus));
      chk("rst_bus1", 32'(bus1), 32'(rst_bus));
      chk("rst_bus3", 32'(bus3), 32'(rst_bus));
      chk("rst_rdy", {29'd0, rdy1, rdy2, rdy3}, 32'd0);
    end

    // Release reset; first edge with rst0=0 must already accept.
    rst = 1'b0;
    cke = 1'b0;
    odt = 1'b0;
    cmd(1'b0, 14'h0, 3'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    #1;
    chk("rel_rdy", {31'd0, rdy1}, 32'd1);

`ifndef DDR2_2T_TIMING_EN
    // 1T back-to-back: ACT, READ, then idle.
    cmd(1'b1, 14'h1A5, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    chk("1t_act", 32'(bus1), 32'(pk(14'h1A5, 3'd2, 0, 1, 1, 0, 0, 0)));
    chk("1t_rdy_a", {31'd0, rdy1}, 32'd1);
    cmd(1'b1, 14'h010, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    chk("1t_read", 32'(bus1), 32'(pk(14'h010, 3'd2, 1, 0, 1, 0, 0, 0)));
    chk("1t_act_s2", 32'(bus2), 32'(pk(14'h1A5, 3'd2, 0, 1, 1, 0, 0, 0)));
    cmd(1'b0, 14'h2AA, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("1t_nop", 32'(bus1), 32'(pk(14'h010, 3'd2, 1, 1, 1, 1, 0, 0)));
    chk("1t_read_s2", 32'(bus2), 32'(pk(14'h010, 3'd2, 1, 0, 1, 0, 0, 0)));
    step();
    chk("1t_nop_s2", 32'(bus2), 32'(pk(14'h010, 3'd2, 1, 1, 1, 1, 0, 0)));
    cs_exp = 1'b0;
`else
    // 2T: WRITE held valid; ready alternates, phase-B input changes ignored.
    cmd(1'b1, 14'h3F0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("2t_a1", 32'(bus1), 32'(pk(14'h3F0, 3'd1, 1, 0, 0, 1, 0, 0)));
    chk("2t_rdy1", {31'd0, rdy1}, 32'd0);
    addr = 14'h123;
    step();
    chk("2t_b1", 32'(bus1), 32'(pk(14'h3F0, 3'd1, 1, 0, 0, 0, 0, 0)));
    chk("2t_rdy2", {31'd0, rdy1}, 32'd1);
    step();
    chk("2t_a2", 32'(bus1), 32'(pk(14'h123, 3'd1, 1, 0, 0, 1, 0, 0)));
    chk("2t_rdy3", {31'd0, rdy1}, 32'd0);
    addr = 14'h0AA;
    cs = 1'b1;
    step();
    chk("2t_b2", 32'(bus1), 32'(pk(14'h123, 3'd1, 1, 0, 0, 0, 0, 0)));
    chk("2t_rdy4", {31'd0, rdy1}, 32'd1);
    cmd(1'b0, 14'h0AA, 3'd1, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    chk("2t_nop", 32'(bus1), 32'(pk(14'h123, 3'd1, 1, 1, 1, 1, 0, 0)));
    // Reset during phase B discards the command.
    cmd(1'b1, 14'h2C3, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    chk("2t_ra", 32'(bus1), 32'(pk(14'h2C3, 3'd3, 0, 1, 1, 1, 0, 0)));
    rst = 1'b1;
    step();
    chk("2t_rst_bus", 32'(bus1), 32'(rst_bus));
    chk("2t_rst_rdy", {31'd0, rdy1}, 32'd0);
    rst = 1'b0;
    cmd(1'b0, 14'h0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1);
    #1;
    chk("2t_rel_rdy", {31'd0, rdy1}, 32'd1);
    step();
    chk("2t_after", 32'(bus1), 32'(rst_bus));
    step();
    chk("2t_after2", 32'(bus1), 32'(rst_bus));
    cs_exp = 1'b1;
`endif

    // CKE/ODT alignment through three stages.
    cmd(1'b1, 14'h055, 3'd5, 1'b0, 1'b1, 1'b1, 1'b0);
    cke = 1'b1;
    odt = 1'b1;
    step();
    chk("cke_m0", {31'd0, k3}, 32'd0);
    cmd(1'b0, 14'h0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    chk("cke_m1", {31'd0, k3}, 32'd0);
    step();
    chk("cke_m2", 32'(bus3), 32'(pk(14'h055, 3'd5, 0, 1, 1, cs_exp, 1, 1)));
    cke = 1'b0;
    odt = 1'b0;
    step();
    chk("cke_off0", {30'd0, k3, o3}, 32'd3);
    step();
    chk("cke_off1", {30'd0, k3, o3}, 32'd3);
    step();
    chk("cke_off2", {30'd0, k3, o3}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
